// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and index helpers for the AXIS packet arbiter
package axis_arb_pkg;
  typedef enum logic {IDLE, XFER} arb_state_t;
  function automatic int clog2(input int v);
    clog2 = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) clog2 = i + 1;
  endfunction
  // First requester strictly after last, wrapping; returns last when nothing is requesting.
  function automatic int rr_next(input logic [15:0] req, input int last, input int n);
    rr_next = last;
    for (int k = n; k >= 1; k--) if (req[4'((last + k) % n)]) rr_next = (last + k) % n;
  endfunction
endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// axis_pkt_arbiter_if: N AXI-Stream lanes flattened onto shared vectors, lane i in slice i
interface axis_pkt_arbiter_if #(parameter int N = 1, DW = 32, UW = 1, DESTW = 1);
  logic [N*DW-1:0] tdata;
  logic [N*DW/8-1:0] tkeep;
  logic [N*UW-1:0] tuser;
  logic [DESTW-1:0] tdest;
  logic [N-1:0] tlast;
  logic [N-1:0] tvalid;
  logic [N-1:0] tready;
  modport master (output tdata, tkeep, tuser, tdest, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXIS register slice; upstream ready is driven straight from a flop
module axis_skid_buf #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_data;
  logic skid_valid;
  assign in_ready = !skid_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || (in_valid && in_ready);
      out_data <= skid_valid ? skid_data : in_data;
      skid_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      skid_data <= in_data;
      skid_valid <= 1'b1;
    end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: whole-packet round-robin AXIS arbiter feeding a FIFO through a skid stage.
// Defining AXIS_ARB_STATS_EN adds per-port accepted-packet counters on pkt_count.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  localparam int DEST_WIDTH = clog2(NUM_PORTS) < 1 ? 1 : clog2(NUM_PORTS)
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  axis_pkt_arbiter_if.slave     s_axis,
  axis_pkt_arbiter_if.master    m_axis,
  input  logic                  fifo_almost_full,
  output logic [DEST_WIDTH-1:0] grant_idx,
  output logic                  busy
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] pkt_count
`endif
);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = TDATA_WIDTH + KW + TUSER_WIDTH + 1 + DEST_WIDTH;
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_XFER = XFER;
  logic [0:0] state;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic [KW-1:0] sel_keep;
  logic [TUSER_WIDTH-1:0] sel_user;
  logic sel_last, sel_valid, skid_ready, fire;
  logic [PW-1:0] out_pl;
  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_user = '0;
    sel_last = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (DEST_WIDTH'(i) == grant_idx) begin
        sel_data = s_axis.tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_keep = s_axis.tkeep[i*KW +: KW];
        sel_user = s_axis.tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        sel_last = s_axis.tlast[i];
        sel_valid = s_axis.tvalid[i];
      end
  end
  assign busy = state == ST_XFER;
  assign fire = busy && sel_valid && skid_ready;
  assign s_axis.tready = busy && skid_ready ? NUM_PORTS'(1) << grant_idx : '0;
  // Almost-full only blocks new grants; a granted packet always runs to its tlast.
  always_ff @(posedge s_aclk or negedge s_aresetn)
    if (!s_aresetn) begin
      state <= ST_IDLE;
      grant_idx <= DEST_WIDTH'(NUM_PORTS - 1);
    end else if (!busy) begin
      if (|s_axis.tvalid && !fifo_almost_full) begin
        grant_idx <= DEST_WIDTH'(rr_next(16'(s_axis.tvalid), int'(grant_idx), NUM_PORTS));
        state <= ST_XFER;
      end
    end else if (fire && sel_last) state <= ST_IDLE;
  axis_skid_buf #(.W(PW)) u_skid (
    .clk(s_aclk),
    .rst_n(s_aresetn),
    .in_data({sel_data, sel_keep, sel_user, sel_last, grant_idx}),
    .in_valid(busy && sel_valid),
    .in_ready(skid_ready),
    .out_data(out_pl),
    .out_valid(m_axis.tvalid),
    .out_ready(m_axis.tready)
  );
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast, m_axis.tdest} = out_pl;
`ifdef AXIS_ARB_STATS_EN
  always_ff @(posedge s_aclk or negedge s_aresetn)
    if (!s_aresetn) pkt_count <= '0;
    else if (fire && sel_last)
      for (int i = 0; i < NUM_PORTS; i++)
        if (DEST_WIDTH'(i) == grant_idx) pkt_count[i*32 +: 32] <= pkt_count[i*32 +: 32] + 32'd1;
`endif
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: randomized packet traffic against a round-robin packet-order model
module tb_axis_pkt_arbiter;
  localparam int NP = 4, DW = 32, UW = 1, DESTW = 2;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0] keep;
    logic [0:0] user;
    logic last;
    logic [1:0] dest;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, afull = 1'b0;
  logic [DESTW-1:0] grant_idx;
  logic busy;
`ifdef AXIS_ARB_STATS_EN
  logic [NP*32-1:0] pkt_count;
`endif
  axis_pkt_arbiter_if #(.N(NP), .DW(DW), .UW(UW), .DESTW(DESTW)) s_bus ();
  axis_pkt_arbiter_if #(.N(1), .DW(DW), .UW(UW), .DESTW(DESTW)) m_bus ();
  axis_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .s_aclk(clk),
    .s_aresetn(rst_n),
    .s_axis(s_bus),
    .m_axis(m_bus),
    .fifo_almost_full(afull),
    .grant_idx(grant_idx),
    .busy(busy)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_count(pkt_count)
`endif
  );
  always #5 clk = ~clk;

  beat_t pq[NP][$];
  beat_t mq[NP][$];
  beat_t exp_q[$];
  int plen[NP][$];
  int cnt[NP];
  int n_vec = 0, n_err = 0, model_last = NP - 1;
  int rdy_mode = 0, af_mode = 0;
  bit gaps = 0;
  logic [NP-1:0] pend = '0, in_pkt = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = $urandom;
      b.keep = 4'($urandom);
      b.user = 1'($urandom);
      b.last = k == len - 1;
      b.dest = 2'(p);
      pq[p].push_back(b);
      mq[p].push_back(b);
    end
    plen[p].push_back(len);
  endtask

  // Reference: whole packets leave in cyclic port order starting after the last winner.
  task automatic model_run();
    int p;
    bit found;
    while (1) begin
      found = 0;
      p = 0;
      for (int k = 1; k <= NP && !found; k++) begin
        p = (model_last + k) % NP;
        found = plen[p].size() > 0;
      end
      if (!found) break;
      repeat (plen[p].pop_front()) exp_q.push_back(mq[p].pop_front());
      cnt[p]++;
      model_last = p;
    end
  endtask

  function automatic int queued();
    queued = 0;
    for (int i = 0; i < NP; i++) queued += pq[i].size();
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string nm, input int max);
    int c = 0;
    while ((exp_q.size() != 0 || busy || queued() != 0) && c < max) begin
      step();
      c++;
    end
    chk(nm, 64'(exp_q.size() + queued()), 64'd0);
  endtask

  task automatic wait_exp(input string nm, input int left);
    int c = 0;
    while (exp_q.size() > left && c < 200) begin
      step();
      c++;
    end
    chk(nm, 64'(exp_q.size() <= left), 64'd1);
  endtask

  // Source drivers and output monitor, all on the falling edge.
  initial begin : drv
    beat_t b, g;
    bit v, lf;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = '0;
        in_pkt = '0;
      end
      lf = 0;
      for (int i = 0; i < NP; i++)
        if (pend[i]) begin
          b = pq[i].pop_front();
          lf |= b.last;
          in_pkt[i] = !b.last;
        end
      for (int i = 0; i < NP; i++) begin
        b = '0;
        v = 0;
        if (pq[i].size() > 0) begin
          b = pq[i][0];
          v = !in_pkt[i] || !gaps || $urandom_range(3) != 0;
        end
        s_bus.tvalid[i] = v;
        s_bus.tdata[i*DW +: DW] = b.data;
        s_bus.tkeep[i*4 +: 4] = b.keep;
        s_bus.tuser[i] = b.user[0];
        s_bus.tlast[i] = b.last;
      end
      s_bus.tdest = '0;
      afull = af_mode == 1 || (af_mode == 2 && $urandom_range(4) == 0);
      m_bus.tready[0] = rdy_mode == 0 || (rdy_mode == 1 && $urandom_range(9) < 7);
      chk("one_hot_ready", 64'($countones(s_bus.tready) <= 1), 64'd1);
      pend = s_bus.tvalid & s_bus.tready;
      if (lf) chk("bubble_after_tlast", 64'(pend), 64'd0);
      if (m_bus.tvalid[0] && m_bus.tready[0]) begin
        g = {m_bus.tdata, m_bus.tkeep, m_bus.tuser, m_bus.tlast, m_bus.tdest};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h, expected none", g);
        end else chk("beat", 64'(g), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_m_tvalid", 64'(m_bus.tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_bus.tready), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'(NP - 1));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_data", 64'({m_bus.tdata, m_bus.tkeep, m_bus.tuser, m_bus.tlast, m_bus.tdest}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    // single 3-beat packet: grant one cycle after valid, first beat one cycle later
    add_pkt(0, 3);
    model_run();
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant_idx), 64'd0);
    chk("t1_not_early", 64'(m_bus.tvalid), 64'd0);
    step();
    chk("t1_first_beat", 64'(m_bus.tvalid), 64'd1);
    chk("t1_tdest", 64'(m_bus.tdest), 64'd0);
    drain("t1_drain", 50);
    // all ports contend with 2-beat packets
    for (int p = 0; p < NP; p++) add_pkt(p, 2);
    model_run();
    drain("t2_drain", 100);
    // output stall mid-packet
    add_pkt(3, 8);
    model_run();
    wait_exp("t3_progress", 5);
    rdy_mode = 2;
    step(5);
    chk("t3_stall_s_tready", 64'(s_bus.tready), 64'd0);
    chk("t3_stall_m_tvalid", 64'(m_bus.tvalid), 64'd1);
    chk("t3_stall_busy", 64'(busy), 64'd1);
    rdy_mode = 0;
    drain("t3_drain", 100);
    // almost-full gates new grants only
    af_mode = 1;
    add_pkt(1, 4);
    model_run();
    step(3);
    chk("t4_no_grant_busy", 64'(busy), 64'd0);
    chk("t4_no_grant_ready", 64'(s_bus.tready), 64'd0);
    af_mode = 0;
    step();
    chk("t4_grant", 64'(grant_idx), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    step();
    af_mode = 1;
    drain("t4_drain_afull", 50);
    chk("t4_done_idle", 64'(busy), 64'd0);
    af_mode = 0;
    // asynchronous reset in the middle of a packet
    add_pkt(2, 10);
    model_run();
    wait_exp("t5_progress", 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_m_tvalid", 64'(m_bus.tvalid), 64'd0);
    chk("t5_s_tready", 64'(s_bus.tready), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant", 64'(grant_idx), 64'(NP - 1));
    for (int i = 0; i < NP; i++) begin
      pq[i].delete();
      mq[i].delete();
      plen[i].delete();
      cnt[i] = 0;
    end
    exp_q.delete();
    model_last = NP - 1;
    step(2);
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) add_pkt(p, 2);
    model_run();
    step();
    chk("t5_first_grant", 64'(grant_idx), 64'd0);
    drain("t5_drain", 100);
    // randomized rounds with source gaps, output backpressure and almost-full noise
    gaps = 1;
    for (int r = 0; r < 8; r++) begin
      rdy_mode = $urandom_range(1);
      af_mode = 2 * $urandom_range(1);
      for (int p = 0; p < NP; p++) repeat ($urandom_range(3)) add_pkt(p, $urandom_range(6, 1));
      model_run();
      drain("rand_drain", 3000);
    end
    rdy_mode = 0;
    af_mode = 0;
`ifdef AXIS_ARB_STATS_EN
    for (int i = 0; i < NP; i++) chk("stats_rand", 64'(pkt_count[i*32 +: 32]), 64'(cnt[i]));
    step();
    rst_n = 1'b0;
    step();
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    model_last = NP - 1;
    rst_n = 1'b1;
    repeat (5) add_pkt(2, $urandom_range(4, 1));
    add_pkt(0, 2);
    model_run();
    drain("t6_drain", 300);
    for (int i = 0; i < NP; i++) chk("t6_pkt_count", 64'(pkt_count[i*32 +: 32]), 64'(cnt[i]));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
